// File: rtl/serial_compare_ctrl.sv
// serial_compare_ctrl
//   Drives one shared, purely combinational 1-bit comparator cell to compare
//   two WIDTH-bit operands MSB-first, one bit per clock. It stops at the first
//   differing bit and returns a registered one-hot h/e/l result together with
//   a one-cycle done pulse.
//
//   Optional feature macro: SERIAL_CMP_SIGNED_EN
//     defined     -> two's complement compare. A difference found on the MSB
//                    step has its h/l sense swapped.
//     not defined -> unsigned magnitude compare, and no swap logic exists.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start           request, accepted only while ready=1
//   a_in, b_in      operands, captured on the accepting edge
//   ready           high while idle (decoded from the state register)
//   done            one-cycle pulse; h/e/l are valid from this cycle on
//   h, e, l         registered one-hot result (A>B, A==B, A<B)
//   cmp_a, cmp_b    current bit pair sent to the shared comparator
//   cmp_h/e/l       shared comparator outputs, sampled in the same cycle
module serial_compare_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ready,
  output logic             done,
  output logic             h,
  output logic             e,
  output logic             l,
  output logic             cmp_a,
  output logic             cmp_b,
  input  logic             cmp_h,
  input  logic             cmp_e,
  input  logic             cmp_l
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic             load_ops;
  logic             res_load, res_h, res_e, res_l;
  logic             bit_eq, bit_gt;

  // Resolve the comparator outputs in priority order: e, then h, then l.
  // If all three are low, the bit pair is treated as equal.
  always_comb begin
    bit_eq = cmp_e | ~(cmp_h | cmp_l);
`ifdef SERIAL_CMP_SIGNED_EN
    // The sign bit carries negative weight, so its sense flips on the MSB step.
    bit_gt = cmp_h ^ (idx == IDX_MSB);
`else
    bit_gt = cmp_h;
`endif
  end

  // Next-state and result decode.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    load_ops  = 1'b0;
    res_load  = 1'b0;
    res_h     = 1'b0;
    res_e     = 1'b0;
    res_l     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load_ops  = 1'b1;
          idx_nxt   = IDX_MSB;
          state_nxt = S_CMP;
        end
      end
      S_CMP: begin
        if (!bit_eq) begin
          res_load  = 1'b1;
          res_h     = bit_gt;
          res_l     = ~bit_gt;
          state_nxt = S_DONE;
        end else if (idx == '0) begin
          res_load  = 1'b1;
          res_e     = 1'b1;
          state_nxt = S_DONE;
        end else begin
          idx_nxt = idx - IDX_W'(1);
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, index, operand and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= IDX_MSB;
      a_q   <= '0;
      b_q   <= '0;
      done  <= 1'b0;
      h     <= 1'b0;
      e     <= 1'b0;
      l     <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      done  <= (state_nxt == S_DONE);
      if (load_ops) begin
        a_q <= a_in;
        b_q <= b_in;
      end
      if (res_load) begin
        h <= res_h;
        e <= res_e;
        l <= res_l;
      end
    end
  end

  assign ready = (state == S_IDLE);

  // The comparator cell sees zeros whenever no compare is in progress.
  assign cmp_a = (state == S_CMP) & a_q[idx];
  assign cmp_b = (state == S_CMP) & b_q[idx];

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed-vector bench for serial_compare_ctrl (WIDTH=8). It models the shared
// 1-bit comparator and can force non-one-hot comparator outputs. Each issued
// request pushes its expected done cycle and its h/e/l result. A monitor pops
// and checks that entry whenever done is seen.
module tb_serial_compare_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in, b_in;
  logic         ready, done, h, e, l;
  logic         cmp_a, cmp_b, cmp_h, cmp_e, cmp_l;
  int           cmp_mode;
  int           cyc;
  int           errors;
  int           checks;

  typedef struct {
    int   cyc;
    logic h;
    logic e;
    logic l;
  } exp_t;
  exp_t exp_q[$];

  serial_compare_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .ready (ready),
    .done  (done),
    .h     (h),
    .e     (e),
    .l     (l),
    .cmp_a (cmp_a),
    .cmp_b (cmp_b),
    .cmp_h (cmp_h),
    .cmp_e (cmp_e),
    .cmp_l (cmp_l)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Shared comparator cell. Mode 1 drives all outputs low; mode 2 drives h and l together.
  always_comb begin
    case (cmp_mode)
      1: {cmp_h, cmp_e, cmp_l} = 3'b000;
      2: {cmp_h, cmp_e, cmp_l} = 3'b101;
      default: begin
        cmp_h = cmp_a & ~cmp_b;
        cmp_e = ~(cmp_a ^ cmp_b);
        cmp_l = ~cmp_a & cmp_b;
      end
    endcase
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 with nothing outstanding (cycle %0d)", cyc);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        check("done_cycle", 32'(cyc), 32'(x.cyc));
        check("res_h", 32'(h), 32'(x.h));
        check("res_e", 32'(e), 32'(x.e));
        check("res_l", 32'(l), 32'(x.l));
        check("ready_at_done", 32'(ready), 32'd0);
      end
    end
  end

  // Called at a negedge. Presents one request and returns one cycle later,
  // after scrambling the operand inputs.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input int k,
                       input logic eh, input logic ee, input logic el, input bit push);
    int c;
    c     = cyc;
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    if (push) exp_q.push_back('{c + k + 1, eh, ee, el});
    @(negedge clk);
    start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ready && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout: ready=%0b outstanding=%0d", ready, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] av, bv;
    int c;
    errors   = 0;
    checks   = 0;
    cyc      = 0;
    cmp_mode = 0;
    rst      = 1'b1;
    start    = 1'b0;
    a_in     = '0;
    b_in     = '0;
    repeat (2) @(negedge clk);

    // State immediately after reset.
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_hel", 32'({h, e, l}), 32'd0);
    check("rst_cmp_ab", 32'({cmp_a, cmp_b}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: equal operands use all 8 bit steps.
    issue(8'hA5, 8'hA5, 8, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_idle();

    // 2: MSB differs, so the compare ends after one bit step.
`ifdef SERIAL_CMP_SIGNED_EN
    issue(8'h80, 8'h7F, 1, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_idle();
    issue(8'h7F, 8'h80, 1, 1'b1, 1'b0, 1'b0, 1'b1);
`else
    issue(8'h80, 8'h7F, 1, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_idle();
    issue(8'h7F, 8'h80, 1, 1'b0, 1'b0, 1'b1, 1'b1);
`endif
    wait_idle();

    // 3: LSB differs, and cmp_a/cmp_b present bits 7..0 in order.
    av = 8'h12;
    bv = 8'h13;
    issue(av, bv, 8, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = W - 1; i >= 0; i--) begin
      check("cmp_a_bit", 32'(cmp_a), 32'(av[i]));
      check("cmp_b_bit", 32'(cmp_b), 32'(bv[i]));
      if (i > 0) @(negedge clk);
    end
    wait_idle();
    check("idle_cmp_ab", 32'({cmp_a, cmp_b}), 32'd0);

    // 4: a second request made while busy is ignored.
    issue(8'h01, 8'h00, 8, 1'b1, 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    a_in  = 8'hFF;
    b_in  = 8'h00;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (12) @(negedge clk);
    check("no_extra_accept", 32'(ready), 32'd1);

    // 5: reset during the third bit step aborts the compare with no done.
    issue(8'h0F, 8'h0E, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_hel", 32'({h, e, l}), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    repeat (12) @(negedge clk);
    issue(8'h0F, 8'h0E, 8, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_idle();

    // 6: start held high re-accepts every 10 cycles.
    c     = cyc;
    start = 1'b1;
    a_in  = 8'h00;
    b_in  = 8'h00;
    exp_q.push_back('{c + 9,  1'b0, 1'b1, 1'b0});
    exp_q.push_back('{c + 19, 1'b0, 1'b1, 1'b0});
    exp_q.push_back('{c + 29, 1'b0, 1'b1, 1'b0});
    repeat (25) @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Comparator outputs all low are treated as equal.
    cmp_mode = 1;
    issue(8'h5A, 8'h3C, 8, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_idle();

    // Both h and l asserted: h takes priority.
    cmp_mode = 2;
`ifdef SERIAL_CMP_SIGNED_EN
    issue(8'h00, 8'h00, 1, 1'b0, 1'b0, 1'b1, 1'b1);
`else
    issue(8'h00, 8'h00, 1, 1'b1, 1'b0, 1'b0, 1'b1);
`endif
    wait_idle();
    cmp_mode = 0;

    // The result holds while idle.
    repeat (3) @(negedge clk);
`ifdef SERIAL_CMP_SIGNED_EN
    check("hold_hel", 32'({h, e, l}), 32'b001);
`else
    check("hold_hel", 32'({h, e, l}), 32'b100);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
